as_gpio_out: RTL and testbench

//  Memory-mapped GPIO output port of as_top_mem. Sits between the core's data-memory store path and the chip outputs gpio_o/gpioAddr_o/cs_o.

---
 rtl/as_gpio_out_pkg.sv | 30 +++
 rtl/as_gpio_out_if.sv | 33 +++
 rtl/as_gpio_fifo.sv | 63 ++++++
 rtl/as_gpio_out.sv | 133 +++++++++++++
 tb/tb_as_gpio_out.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/as_gpio_out_pkg.sv
// as_pack: shared definitions for the memory-mapped GPIO output port.
//   GPIO_BASE       4 KiB aligned base of the GPIO window in the data address map
//   NR_GPIOS        default width of gpio_o
//   GPIO_ADDR_WIDTH default width of gpioAddr_o
//   gpio_state_t    replay FSM states
//   gpio_entry_t    one queued store at the default widths
//   base_hit()      true when a byte address falls inside the 4 KiB window of a base
package as_pack;

    localparam logic [63:0] GPIO_BASE       = 64'h0000_0000_8000_0000;
    localparam int          NR_GPIOS        = 16;
    localparam int          GPIO_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        GPIO_IDLE,
        GPIO_DRIVE,
        GPIO_GAP
    } gpio_state_t;

    typedef struct packed {
        logic [GPIO_ADDR_WIDTH-1:0] addr;
        logic [NR_GPIOS-1:0]        data;
    } gpio_entry_t;

    // Only the page number is compared; the low 12 bits select the register.
    function automatic logic base_hit(input logic [63:0] addr, input logic [63:0] base);
        return addr[63:12] == base[63:12];
    endfunction

endpackage

// File: rtl/as_gpio_out_if.sv
// as_gpio_out_if: store path from the MEM stage and the chip-side GPIO outputs.
//   master: the core side (drives we_i/addr_i/wdata_i, observes stall_o and outputs)
//   slave : as_gpio_out
//   we_i, addr_i, wdata_i        store request, held by the core while stall_o=1
//   stall_o                      store not accepted this cycle
//   gpio_o, gpioAddr_o, cs_o     replayed store and its one-cycle strobe
//   re_i, rdata_o                load readback, present only with AS_GPIO_RDBACK_EN
interface as_gpio_out_if #(
    parameter int GPIO_W = 16,
    parameter int ADDR_W = 12
);
    logic              we_i;
    logic [63:0]       addr_i;
    logic [63:0]       wdata_i;
    logic              stall_o;
    logic [GPIO_W-1:0] gpio_o;
    logic [ADDR_W-1:0] gpioAddr_o;
    logic              cs_o;
`ifdef AS_GPIO_RDBACK_EN
    logic              re_i;
    logic [63:0]       rdata_o;

    modport master (output we_i, addr_i, wdata_i, re_i,
                    input  stall_o, gpio_o, gpioAddr_o, cs_o, rdata_o);
    modport slave  (input  we_i, addr_i, wdata_i, re_i,
                    output stall_o, gpio_o, gpioAddr_o, cs_o, rdata_o);
`else
    modport master (output we_i, addr_i, wdata_i,
                    input  stall_o, gpio_o, gpioAddr_o, cs_o);
    modport slave  (input  we_i, addr_i, wdata_i,
                    output stall_o, gpio_o, gpioAddr_o, cs_o);
`endif
endinterface

// File: rtl/as_gpio_fifo.sv
// as_gpio_fifo: synchronous FIFO for queued GPIO stores.
//   clk_i, rst_i      clock, asynchronous active-high reset (empties the FIFO)
//   push_i, wdata_i   write an entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   rdata_o           head entry, valid while empty_o=0
//   full_o, empty_o   status flags
//   count_o           current fill level, 0..DEPTH
module as_gpio_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    assign full_o  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty_o = (wr_ptr == rd_ptr);
    assign count_o = wr_ptr - rd_ptr;
    assign rdata_o = mem[rd_ptr[IDX_W-1:0]];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/as_gpio_out.sv
// as_gpio_out: memory-mapped GPIO output port.
// Stores that hit the 4 KiB window at BASE_ADDR are queued and replayed, in
// order, as one-cycle cs_o strobes carrying address and data. stall_o holds
// the core while the queue is full.
//   clk_i, rst_i   core clock, asynchronous active-high reset
//   bus (slave)    we_i/addr_i/wdata_i in; stall_o, gpio_o, gpioAddr_o, cs_o out
// Optional feature macro AS_GPIO_RDBACK_EN adds re_i/rdata_o readback.
// Status register (BASE+0xFF8) layout:
//   [63:56] fill count, [55:11] zero, [10] empty, [9] full, [8:0] gpio_o[8:0]
module as_gpio_out
    import as_pack::*;
#(
    parameter int          GPIO_W     = NR_GPIOS,
    parameter int          ADDR_W     = GPIO_ADDR_WIDTH,
    parameter int          FIFO_DEPTH = 4,
    parameter int          GAP_CYC    = 0,
    parameter logic [63:0] BASE_ADDR  = GPIO_BASE
) (
    input  logic          clk_i,
    input  logic          rst_i,
    as_gpio_out_if.slave  bus
);
    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int         ENTRY_W  = ADDR_W + GPIO_W;
    localparam logic [3:0] GAP_LOAD = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

    gpio_state_t       state;
    logic              hit;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [GPIO_W-1:0] gpio_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cs_q;
    logic [3:0]        gap_cnt;
    logic              unused_bits;

    assign hit         = bus.we_i & base_hit(bus.addr_i, BASE_ADDR);
    // A pop in this same cycle does not free the slot for the stalled store.
    assign bus.stall_o = hit & fifo_full;
    assign pop         = (state == GPIO_IDLE) & ~fifo_empty;

    as_gpio_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hit & ~fifo_full),
        .pop_i   (pop),
        .wdata_i ({bus.addr_i[ADDR_W-1:0], bus.wdata_i[GPIO_W-1:0]}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Replay FSM: IDLE pops and strobes, DRIVE drops the strobe, GAP pads
    // the spacing. gpio_o/gpioAddr_o only change on a pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= GPIO_IDLE;
            gpio_q  <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                GPIO_IDLE: begin
                    if (!fifo_empty) begin
                        gpio_q <= head[GPIO_W-1:0];
                        addr_q <= head[ENTRY_W-1:GPIO_W];
                        cs_q   <= 1'b1;
                        state  <= GPIO_DRIVE;
                    end
                end
                GPIO_DRIVE: begin
                    cs_q <= 1'b0;
                    if (GAP_CYC == 0) begin
                        state <= GPIO_IDLE;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GPIO_GAP;
                    end
                end
                GPIO_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= GPIO_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= GPIO_IDLE;
                end
            endcase
        end
    end

    assign bus.gpio_o     = gpio_q;
    assign bus.gpioAddr_o = addr_q;
    assign bus.cs_o       = cs_q;

`ifdef AS_GPIO_RDBACK_EN
    logic [63:0] rdata_q;
    logic [63:0] gpio_zext;

    assign gpio_zext = 64'(gpio_q);

    // Readback is registered and returns to zero in cycles without a read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (bus.re_i && base_hit(bus.addr_i, BASE_ADDR)) begin
            if (bus.addr_i[11:0] == 12'hFF8) begin
                rdata_q <= {8'(fifo_count), 45'd0, fifo_empty, fifo_full, gpio_zext[8:0]};
            end else begin
                rdata_q <= gpio_zext;
            end
        end else begin
            rdata_q <= '0;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign unused_bits = ^{bus.wdata_i, bus.addr_i};
`else
    assign unused_bits = ^{bus.wdata_i, bus.addr_i, fifo_count};
`endif

endmodule

// File: tb/tb_as_gpio_out.sv
// tb_as_gpio_out: scoreboard bench for as_gpio_out.
// Instance A uses GAP_CYC=0 and is driven by directed plus random stores.
// Instance B uses GAP_CYC=3 and checks strobe spacing (and readback when
// AS_GPIO_RDBACK_EN is defined).
module tb_as_gpio_out;
    import as_pack::*;

    localparam int          GW    = 16;
    localparam int          AW    = 12;
    localparam int          DEPTH = 4;
    localparam int          GAP_B = 3;
    localparam logic [63:0] BASE  = GPIO_BASE;

    typedef struct {
        logic [AW-1:0] a;
        logic [GW-1:0] d;
    } ent_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [GW-1:0] d;
        int            edge_no;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    bit   mon_en;

    ent_t          pend[$];
    exp_t          expq[$];
    int            next_pop_ok;
    logic [GW-1:0] last_d;
    logic [AW-1:0] last_a;
    int            bq[$];
    logic [GW-1:0] bexp[$];

    as_gpio_out_if #(.GPIO_W(GW), .ADDR_W(AW)) bus_a ();
    as_gpio_out_if #(.GPIO_W(GW), .ADDR_W(AW)) bus_b ();

    as_gpio_out #(
        .GPIO_W(GW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .GAP_CYC(0), .BASE_ADDR(BASE)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a.slave)
    );

    as_gpio_out #(
        .GPIO_W(GW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .GAP_CYC(GAP_B), .BASE_ADDR(BASE)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_window(input bit we, input logic [63:0] addr);
        return we && (addr >= BASE) && (addr < BASE + 64'd4096);
    endfunction

    // One cycle on instance A; the model decides stall and schedules strobes.
    task automatic applyStimulus(input bit we, input logic [63:0] addr,
                                 input logic [63:0] data, output bit stalled);
        int   e_no;
        bit   hit;
        bit   full;
        ent_t ent;
        @(negedge clk);
        bus_a.we_i    = we;
        bus_a.addr_i  = addr;
        bus_a.wdata_i = data;
        e_no    = cyc + 1;
        hit     = in_window(we, addr);
        full    = (pend.size() == DEPTH);
        stalled = hit && full;
        #1 checkOutput("stall_o", 64'(bus_a.stall_o), 64'(stalled));
        if (pend.size() > 0 && e_no >= next_pop_ok) begin
            ent = pend.pop_front();
            expq.push_back('{ent.a, ent.d, e_no});
            next_pop_ok = e_no + 2;
        end
        if (hit && !full) begin
            pend.push_back('{addr[AW-1:0], data[GW-1:0]});
        end
    endtask

    task automatic storeA(input logic [63:0] addr, input logic [63:0] data);
        bit st;
        int tries;
        tries = 0;
        do begin
            applyStimulus(1'b1, addr, data, st);
            tries++;
        end while (st && tries < 20);
        if (st) checkOutput("stall_bound", 64'(tries), 64'd0);
    endtask

    task automatic idleA(input int n);
        bit st;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'd0, 64'd0, st);
    endtask

    task automatic driveB(input bit we, input logic [63:0] addr, input logic [63:0] data);
        bus_b.we_i    = we;
        bus_b.addr_i  = addr;
        bus_b.wdata_i = data;
        if (in_window(we, addr)) bexp.push_back(data[GW-1:0]);
    endtask

    task automatic clearModel();
        pend.delete();
        expq.delete();
        bq.delete();
        bexp.delete();
        next_pop_ok = 0;
        last_d = '0;
        last_a = '0;
    endtask

    // Monitor A: every strobe must match the head of the scoreboard, and
    // outputs must hold between strobes.
    always @(negedge clk) begin
        exp_t x;
        if (mon_en && !rst) begin
            if (bus_a.cs_o) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_cs", 64'd1, 64'd0);
                end else begin
                    x = expq.pop_front();
                    checkOutput("cs_cycle", 64'(cyc), 64'(x.edge_no));
                    checkOutput("gpioAddr_o", 64'(bus_a.gpioAddr_o), 64'(x.a));
                    checkOutput("gpio_o", 64'(bus_a.gpio_o), 64'(x.d));
                    last_d = x.d;
                    last_a = x.a;
                end
            end else begin
                checkOutput("gpio_hold", {32'(bus_a.gpioAddr_o), 32'(bus_a.gpio_o)},
                            {32'(last_a), 32'(last_d)});
            end
        end
    end

    // Monitor B: record strobe cycles and check data order.
    always @(negedge clk) begin
        if (mon_en && !rst && bus_b.cs_o) begin
            bq.push_back(cyc);
            if (bexp.size() == 0) checkOutput("b_unexpected_cs", 64'd1, 64'd0);
            else checkOutput("b_gpio_o", 64'(bus_b.gpio_o), 64'(bexp.pop_front()));
        end
    end

    initial begin
        bit            st;
        int            e_b;
        logic [63:0]   a;
        logic [63:0]   d;
        int            sel;

        cyc = 0; n_checks = 0; n_pass = 0; mon_en = 1'b0;
        clearModel();
        bus_a.we_i = 1'b0; bus_a.addr_i = '0; bus_a.wdata_i = '0;
        driveB(1'b0, 64'd0, 64'd0);
`ifdef AS_GPIO_RDBACK_EN
        bus_a.re_i = 1'b0;
        bus_b.re_i = 1'b0;
`endif
        // Reset held for 10 cycles: all outputs low.
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cs_o", 64'(bus_a.cs_o), 64'd0);
        checkOutput("rst_gpio_o", 64'(bus_a.gpio_o), 64'd0);
        checkOutput("rst_gpioAddr_o", 64'(bus_a.gpioAddr_o), 64'd0);
        checkOutput("rst_stall_o", 64'(bus_a.stall_o), 64'd0);
        checkOutput("rst_b_cs_o", 64'(bus_b.cs_o), 64'd0);
`ifdef AS_GPIO_RDBACK_EN
        checkOutput("rst_rdata_o", bus_b.rdata_o, 64'd0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;
        idleA(5);

        // Single store, then five back-to-back stores.
        storeA(BASE + 64'd4, 64'd7);
        idleA(5);
        for (int i = 0; i < 5; i++) storeA(BASE + 64'(i), 64'(i + 1));
        idleA(12);

        // Fill the queue, then issue out-of-window stores.
        for (int i = 0; i < 6; i++) storeA(BASE + 64'h10 + 64'(i), 64'h100 + 64'(i));
        applyStimulus(1'b1, BASE - 64'd8, 64'hDEAD, st);
        applyStimulus(1'b1, BASE + 64'd4096, 64'hBEEF, st);
        idleA(14);

        // Asynchronous reset pulse with entries queued.
        for (int i = 0; i < 3; i++) storeA(BASE + 64'h20 + 64'(i), 64'h55 + 64'(i));
        bus_a.we_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_cs_o", 64'(bus_a.cs_o), 64'd0);
        checkOutput("arst_gpio_o", 64'(bus_a.gpio_o), 64'd0);
        checkOutput("arst_gpioAddr_o", 64'(bus_a.gpioAddr_o), 64'd0);
        clearModel();
        #1 rst = 1'b0;
        idleA(8);

        // Randomized traffic; a stalled store is held until accepted.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            d = {$urandom, $urandom};
            if (sel < 2) begin
                applyStimulus(1'b0, BASE + 64'($urandom_range(0, 4095)), d, st);
            end else if (sel == 2) begin
                applyStimulus(1'b1, (sel[0] ? BASE - 64'd8 : BASE + 64'd4096 + 64'($urandom_range(0, 255))), d, st);
            end else begin
                a = BASE + 64'($urandom_range(0, 4095));
                storeA(a, d);
            end
        end
        idleA(12);
        checkOutput("drain_expq", 64'(expq.size()), 64'd0);

        // GAP_CYC=3 instance: strobes 2+3 cycles apart.
        e_b = cyc + 1;
        driveB(1'b1, BASE + 64'd4, 64'h0123);
        idleA(1);
        driveB(1'b1, BASE + 64'd8, 64'h0456);
        idleA(1);
        driveB(1'b1, BASE + 64'd12, 64'h0789);
        idleA(1);
        driveB(1'b0, BASE + 64'hFF8, 64'd0);
`ifdef AS_GPIO_RDBACK_EN
        bus_b.re_i = 1'b1;
`endif
        idleA(1);
`ifdef AS_GPIO_RDBACK_EN
        bus_b.re_i = 1'b0;
        checkOutput("rdback_status", bus_b.rdata_o, {8'd2, 45'd0, 1'b0, 1'b0, 9'h123});
`endif
        idleA(16);
        checkOutput("b_strobes", 64'(bq.size()), 64'd3);
        if (bq.size() == 3) begin
            checkOutput("b_first_latency", 64'(bq[0] - e_b), 64'd1);
            checkOutput("b_spacing_1", 64'(bq[1] - bq[0]), 64'(2 + GAP_B));
            checkOutput("b_spacing_2", 64'(bq[2] - bq[1]), 64'(2 + GAP_B));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
